cpu_decoder_pipe: RTL and testbench
===================================

# cpu_decoder_pipe

Parametrised, pipelined successor to the CPU's instruction decoder. Decodes one instruction per cycle into a data-select code and one-hot load enables for an NREG-entry register file plus the OUT and PC registers. Resolves conditional jumps on carry and zero flags, stops on HALT, flags and counts illegal opcodes, and holds a single registered output stage with valid/ready handshakes on both sides. Sits between instruction fetch and the execute/ALU datapath.

## Interface
- NREG, 4, general registers (2..16); RW = clog2(NREG), SW = RW+1
- CNT_W, 8, illegal-opcode counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  decoder accepts this cycle
- opcode  in  4  instruction opcode
- rfield  in  RW  register index field
- cflag, zflag  in  1 each  flags, sampled with the instruction
- resume  in  1  leave HALT
- out_valid  out  1  decoded word valid
- out_ready  in  1  execute consumes word
- ds  out  SW  source select: 0..NREG-1 = register, NREG = IN port, NREG+1 = zero (immediate only)
- load_reg  out  NREG  one-hot register load
- load_out, load_pc  out  1 each  OUT / PC load
- illegal  out  1  word is an illegal-opcode bubble
- halted  out  1  FSM in HALT
- illegal_cnt  out  CNT_W  saturating illegal count

## Operation
- Decode table (r = rfield):
  - 0x0 ADD r,Im: ds=r, load_reg[r]
  - 0x1 MOV r,R0: ds=0, load_reg[r]
  - 0x2 MOV R0,r: ds=r, load_reg[0]
  - 0x3 IN r: ds=NREG, load_reg[r]
  - 0x4 MOV r,Im: ds=NREG+1, load_reg[r]
  - 0x5 OUT r: ds=r, load_out
  - 0x6 OUT Im: ds=NREG+1, load_out
  - 0xD JNZ: ds=NREG+1, load_pc=~zflag
  - 0xE JNC: ds=NREG+1, load_pc=~cflag
  - 0xF JMP: ds=NREG+1, load_pc=1
  - 0xC HALT: no output word; FSM goes to HALT
  - All other opcodes, and r ≥ NREG on any register-using opcode: illegal word. ds=0, all loads 0, illegal=1, out_valid=1, illegal_cnt+1 saturating at 2^CNT_W-1.
- FSM RUN/HALT. RUN: in_ready = ~out_valid | out_ready. HALT: in_ready=0, halted=1. resume in HALT → RUN. resume in RUN is ignored.
- Accepting HALT → HALT next cycle. Any pending output word still drains normally.
- Output register: loads on accept. Holds stable while out_valid & ~out_ready. out_valid clears when consumed with no new accept.
- Flags are used only in the accept cycle; later flag changes do not alter a held word.

## Timing
- Reset values: out_valid=0, ds=0, load_reg=0, load_out=0, load_pc=0, illegal=0, illegal_cnt=0, halted=0, state RUN.
- rst has priority over all inputs, including mid-stall and in HALT.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N. Throughput is 1/cycle while out_ready=1.
- Simultaneous consume + accept: the old word retires and the new word replaces it in the same edge; out_valid stays 1.
- Accepting HALT while the previous word is consumed in the same cycle: out_valid→0 and halted→1 at that edge.
- Load enables are meaningful only with out_valid=1. They are zeroed whenever out_valid=0.

## Structure
- Package cpu_decoder_pkg holds the opcode localparams (OP_ADD … OP_JMP, OP_HALT) and the ds encoding helpers (DS_IN = NREG, DS_ZERO = NREG+1 as functions of NREG).
- One sub-module, cpu_decode_rom: purely combinational table mapping (opcode, rfield, cflag, zflag) to {ds, load_reg, load_out, load_pc, illegal, is_halt}.
- The top level holds the FSM, output register, handshake logic and counter.

## Test plan
- NREG=4, out_ready=1, stream 0x4/r2, 0x0/r1, 0x5/r3 → one cycle each: ds=5, load_reg=0100; then ds=1, load_reg=0010; then ds=3, load_out=1.
- 0xE with cflag=1, then 0xE with cflag=0 → load_pc=0, then load_pc=1. Flip cflag while out_ready=0 → held word unchanged.
- out_ready low for 3 cycles with in_valid high → in_ready=0 and outputs stable; release → next word appears the following cycle with no loss or duplication.
- HALT accepted → halted=1, in_ready=0 for 10 cycles; resume pulse → RUN next cycle and the next instruction is accepted.
- CNT_W=2, send opcode 0x8 five times → illegal=1 each with all loads 0; illegal_cnt goes 1,2,3,3,3.
- NREG=3, opcode 0x0 with r=3 → illegal. Assert rst mid-stall and in HALT → every output at its reset value after the edge.

Source files
------------

// File: rtl/cpu_decoder_pkg.sv
// cpu_decoder_pkg: shared opcode values, data-select encoding helpers and FSM state type
// for the pipelined instruction decoder.
package cpu_decoder_pkg;

  localparam logic [3:0] OP_ADD      = 4'h0;  // ADD r,Im
  localparam logic [3:0] OP_MOV_R_R0 = 4'h1;  // MOV r,R0
  localparam logic [3:0] OP_MOV_R0_R = 4'h2;  // MOV R0,r
  localparam logic [3:0] OP_IN       = 4'h3;  // IN r
  localparam logic [3:0] OP_MOV_R_IM = 4'h4;  // MOV r,Im
  localparam logic [3:0] OP_OUT_R    = 4'h5;  // OUT r
  localparam logic [3:0] OP_OUT_IM   = 4'h6;  // OUT Im
  localparam logic [3:0] OP_HALT     = 4'hC;
  localparam logic [3:0] OP_JNZ      = 4'hD;
  localparam logic [3:0] OP_JNC      = 4'hE;
  localparam logic [3:0] OP_JMP      = 4'hF;

  // ds codes above the register range: IN port, then the zero source (immediate only).
  function automatic int unsigned ds_in(int unsigned nreg);
    return nreg;
  endfunction

  function automatic int unsigned ds_zero(int unsigned nreg);
    return nreg + 1;
  endfunction

  typedef enum logic {StRun, StHalt} state_e;

endpackage

// File: rtl/cpu_decode_rom.sv
// cpu_decode_rom: combinational decode table.
//   opcode, rfield, cflag, zflag  -> instruction fields and flags
//   ds, load_reg, load_out, load_pc -> data select and load enables
//   illegal                       -> unknown opcode or out-of-range register index
//   is_halt                       -> HALT instruction (produces no output word)
module cpu_decode_rom
  import cpu_decoder_pkg::*;
#(
  parameter  int unsigned NREG = 4,
  localparam int unsigned RW   = $clog2(NREG),
  localparam int unsigned SW   = RW + 1
) (
  input  logic [3:0]      opcode,
  input  logic [RW-1:0]   rfield,
  input  logic            cflag,
  input  logic            zflag,
  output logic [SW-1:0]   ds,
  output logic [NREG-1:0] load_reg,
  output logic            load_out,
  output logic            load_pc,
  output logic            illegal,
  output logic            is_halt
);

  localparam logic [SW-1:0] DsIn   = SW'(ds_in(NREG));
  localparam logic [SW-1:0] DsZero = SW'(ds_zero(NREG));

  logic            r_ok;
  logic            uses_reg;
  logic [SW-1:0]   r_ds;
  logic [NREG-1:0] r_hot;

  // Widen by one bit so the range check stays meaningful when NREG is a power of two.
  assign r_ok  = {1'b0, rfield} < (RW + 1)'(NREG);
  assign r_ds  = SW'(rfield);
  assign r_hot = NREG'(1) << rfield;

  always_comb begin
    ds       = '0;
    load_reg = '0;
    load_out = 1'b0;
    load_pc  = 1'b0;
    illegal  = 1'b0;
    is_halt  = 1'b0;
    uses_reg = 1'b0;
    case (opcode)
      OP_ADD:      begin uses_reg = 1'b1; ds = r_ds;  load_reg = r_hot;     end
      OP_MOV_R_R0: begin uses_reg = 1'b1; ds = '0;    load_reg = r_hot;     end
      OP_MOV_R0_R: begin uses_reg = 1'b1; ds = r_ds;  load_reg = NREG'(1);  end
      OP_IN:       begin uses_reg = 1'b1; ds = DsIn;  load_reg = r_hot;     end
      OP_MOV_R_IM: begin uses_reg = 1'b1; ds = DsZero; load_reg = r_hot;    end
      OP_OUT_R:    begin uses_reg = 1'b1; ds = r_ds;  load_out = 1'b1;      end
      OP_OUT_IM:   begin ds = DsZero; load_out = 1'b1;                      end
      OP_JNZ:      begin ds = DsZero; load_pc = ~zflag;                     end
      OP_JNC:      begin ds = DsZero; load_pc = ~cflag;                     end
      OP_JMP:      begin ds = DsZero; load_pc = 1'b1;                       end
      OP_HALT:     is_halt = 1'b1;
      default:     illegal = 1'b1;
    endcase
    // An out-of-range register index turns any register-using opcode into a bubble.
    if (uses_reg && !r_ok) begin
      ds       = '0;
      load_reg = '0;
      load_out = 1'b0;
      illegal  = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_decoder_pipe.sv
// cpu_decoder_pipe: pipelined instruction decoder with one registered output stage.
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   in_valid/in_ready          fetch-side handshake; opcode, rfield, cflag, zflag with it
//   resume                     leaves HALT
//   out_valid/out_ready        execute-side handshake for the decoded word
//   ds, load_reg, load_out, load_pc, illegal   decoded word (all zero when out_valid=0)
//   halted                     FSM is in HALT
//   illegal_cnt                saturating count of accepted illegal instructions
module cpu_decoder_pipe
  import cpu_decoder_pkg::*;
#(
  parameter  int unsigned NREG  = 4,
  parameter  int unsigned CNT_W = 8,
  localparam int unsigned RW    = $clog2(NREG),
  localparam int unsigned SW    = RW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [RW-1:0]    rfield,
  input  logic             cflag,
  input  logic             zflag,
  input  logic             resume,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SW-1:0]    ds,
  output logic [NREG-1:0]  load_reg,
  output logic             load_out,
  output logic             load_pc,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [SW-1:0]   dec_ds;
  logic [NREG-1:0] dec_load_reg;
  logic            dec_load_out, dec_load_pc, dec_illegal, dec_is_halt;

  cpu_decode_rom #(
    .NREG (NREG)
  ) u_rom (
    .opcode   (opcode),
    .rfield   (rfield),
    .cflag    (cflag),
    .zflag    (zflag),
    .ds       (dec_ds),
    .load_reg (dec_load_reg),
    .load_out (dec_load_out),
    .load_pc  (dec_load_pc),
    .illegal  (dec_illegal),
    .is_halt  (dec_is_halt)
  );

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [SW-1:0]   ds_q, ds_d;
  logic [NREG-1:0] load_reg_q, load_reg_d;
  logic            load_out_q, load_out_d;
  logic            load_pc_q, load_pc_d;
  logic            illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            accept;

  assign in_ready = (state_q == StRun) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    ds_d        = ds_q;
    load_reg_d  = load_reg_q;
    load_out_d  = load_out_q;
    load_pc_d   = load_pc_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StRun:  if (accept && dec_is_halt) state_d = StHalt;
      StHalt: if (resume) state_d = StRun;
    endcase

    if (accept && !dec_is_halt) begin
      out_valid_d = 1'b1;
      ds_d        = dec_ds;
      load_reg_d  = dec_load_reg;
      load_out_d  = dec_load_out;
      load_pc_d   = dec_load_pc;
      illegal_d   = dec_illegal;
    end else if (accept || (out_valid_q && out_ready)) begin
      // Accepting HALT implies the old word is gone (in_ready), so it also empties the stage.
      out_valid_d = 1'b0;
      ds_d        = '0;
      load_reg_d  = '0;
      load_out_d  = 1'b0;
      load_pc_d   = 1'b0;
      illegal_d   = 1'b0;
    end

    if (accept && dec_illegal && (cnt_q != CntMax)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      out_valid_q <= 1'b0;
      ds_q        <= '0;
      load_reg_q  <= '0;
      load_out_q  <= 1'b0;
      load_pc_q   <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      ds_q        <= ds_d;
      load_reg_q  <= load_reg_d;
      load_out_q  <= load_out_d;
      load_pc_q   <= load_pc_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign ds          = ds_q;
  assign load_reg    = load_reg_q;
  assign load_out    = load_out_q;
  assign load_pc     = load_pc_q;
  assign illegal     = illegal_q;
  assign halted      = (state_q == StHalt);
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_decoder_pipe.sv
// tb_cpu_decoder_pipe: table vectors, hand-written handshake/HALT/reset sequences and a
// randomized run against a transaction-level model, on an NREG=4/CNT_W=2 instance plus an
// NREG=3 instance for the out-of-range register index.
module tb_cpu_decoder_pipe;

  typedef struct packed {
    logic [2:0] ds;
    logic [3:0] lr;
    logic       lo;
    logic       lp;
    logic       ill;
  } word_t;

  typedef struct {
    logic [3:0] op;
    logic [1:0] r;
    logic       c;
    logic       z;
    word_t      exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, in_valid, cflag, zflag, resume, out_ready;
  logic [3:0] opcode;
  logic [1:0] rfield;
  logic       in_ready, out_valid, load_out, load_pc, illegal, halted;
  logic [2:0] ds;
  logic [3:0] load_reg;
  logic [1:0] illegal_cnt;

  logic       in_valid3;
  logic [3:0] opcode3;
  logic [1:0] rfield3;
  logic       in_ready3, out_valid3, load_out3, load_pc3, illegal3, halted3;
  logic [2:0] ds3;
  logic [2:0] load_reg3;
  logic [7:0] illegal_cnt3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_decoder_pipe #(.NREG(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .rfield(rfield), .cflag(cflag), .zflag(zflag), .resume(resume), .out_valid(out_valid),
    .out_ready(out_ready), .ds(ds), .load_reg(load_reg), .load_out(load_out),
    .load_pc(load_pc), .illegal(illegal), .halted(halted), .illegal_cnt(illegal_cnt)
  );

  cpu_decoder_pipe #(.NREG(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .opcode(opcode3),
    .rfield(rfield3), .cflag(cflag), .zflag(zflag), .resume(resume), .out_valid(out_valid3),
    .out_ready(out_ready), .ds(ds3), .load_reg(load_reg3), .load_out(load_out3),
    .load_pc(load_pc3), .illegal(illegal3), .halted(halted3), .illegal_cnt(illegal_cnt3)
  );

  function automatic word_t w_of(int d, logic [3:0] lr, logic lo, logic lp, logic ill);
    word_t w;
    w.ds = 3'(d); w.lr = lr; w.lo = lo; w.lp = lp; w.ill = ill;
    return w;
  endfunction

  // Observed vector layout: {out_valid, word, halted, in_ready, illegal_cnt}.
  function automatic logic [14:0] obs();
    return {out_valid, ds, load_reg, load_out, load_pc, illegal, halted, in_ready, illegal_cnt};
  endfunction

  function automatic logic [14:0] mk(logic ov, word_t w, logic h, logic ir, logic [1:0] c);
    word_t wz;
    wz = ov ? w : '0;
    return {ov, wz, h, ir, c};
  endfunction

  task automatic cmp(string name, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check(string name, logic [14:0] want);
    cmp(name, 32'(obs()), 32'(want));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_valid3 = 1'b0; resume = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Reference decode for NREG=4 (every 2-bit index is a valid register).
  function automatic void ref_dec(input logic [3:0] op, input logic [1:0] r, input logic c,
                                  input logic z, output word_t w, output logic h);
    logic [3:0] hot;
    hot = 4'd1 << r;
    w = '0;
    h = 1'b0;
    case (op)
      4'h0: w = w_of(r, hot, 0, 0, 0);
      4'h1: w = w_of(0, hot, 0, 0, 0);
      4'h2: w = w_of(r, 4'b0001, 0, 0, 0);
      4'h3: w = w_of(4, hot, 0, 0, 0);
      4'h4: w = w_of(5, hot, 0, 0, 0);
      4'h5: w = w_of(r, 4'b0000, 1, 0, 0);
      4'h6: w = w_of(5, 4'b0000, 1, 0, 0);
      4'hC: h = 1'b1;
      4'hD: w = w_of(5, 4'b0000, 0, !z, 0);
      4'hE: w = w_of(5, 4'b0000, 0, !c, 0);
      4'hF: w = w_of(5, 4'b0000, 0, 1, 0);
      default: w = w_of(0, 4'b0000, 0, 0, 1);
    endcase
  endfunction

  initial begin
    vec_t  vt[13];
    int    ecnt[5];
    int    exp_cnt;
    logic  m_valid, m_halt, h, ir;
    word_t m_w, w;
    int    m_cnt;

    opcode = '0; rfield = '0; cflag = 1'b0; zflag = 1'b0;
    opcode3 = '0; rfield3 = '0;

    vt[0]  = '{4'h4, 2'd2, 1'b0, 1'b0, w_of(5, 4'b0100, 0, 0, 0)};
    vt[1]  = '{4'h0, 2'd1, 1'b0, 1'b0, w_of(1, 4'b0010, 0, 0, 0)};
    vt[2]  = '{4'h5, 2'd3, 1'b0, 1'b0, w_of(3, 4'b0000, 1, 0, 0)};
    vt[3]  = '{4'h1, 2'd3, 1'b0, 1'b0, w_of(0, 4'b1000, 0, 0, 0)};
    vt[4]  = '{4'h2, 2'd2, 1'b0, 1'b0, w_of(2, 4'b0001, 0, 0, 0)};
    vt[5]  = '{4'h3, 2'd1, 1'b0, 1'b0, w_of(4, 4'b0010, 0, 0, 0)};
    vt[6]  = '{4'h6, 2'd0, 1'b0, 1'b0, w_of(5, 4'b0000, 1, 0, 0)};
    vt[7]  = '{4'hD, 2'd0, 1'b0, 1'b0, w_of(5, 4'b0000, 0, 1, 0)};
    vt[8]  = '{4'hD, 2'd0, 1'b0, 1'b1, w_of(5, 4'b0000, 0, 0, 0)};
    vt[9]  = '{4'hE, 2'd0, 1'b1, 1'b0, w_of(5, 4'b0000, 0, 0, 0)};
    vt[10] = '{4'hE, 2'd0, 1'b0, 1'b0, w_of(5, 4'b0000, 0, 1, 0)};
    vt[11] = '{4'hF, 2'd2, 1'b1, 1'b1, w_of(5, 4'b0000, 0, 1, 0)};
    vt[12] = '{4'h8, 2'd1, 1'b0, 1'b0, w_of(0, 4'b0000, 0, 0, 1)};
    ecnt = '{1, 2, 3, 3, 3};

    // Reset state and back-to-back decode table.
    do_reset();
    check("reset", mk(0, '0, 0, 1, 0));
    exp_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1; opcode = vt[i].op; rfield = vt[i].r; cflag = vt[i].c; zflag = vt[i].z;
      tick();
      if (vt[i].exp.ill && exp_cnt < 3) exp_cnt++;
      check($sformatf("vec%0d", i), mk(1, vt[i].exp, 0, 1, 2'(exp_cnt)));
    end
    in_valid = 1'b0;
    tick();
    check("table_drain", mk(0, '0, 0, 1, 2'(exp_cnt)));

    // Stall with flag changes: held word stays put, next word appears once released.
    do_reset();
    in_valid = 1'b1; opcode = 4'hE; rfield = 2'd0; cflag = 1'b0; out_ready = 1'b1;
    tick();
    check("jnc_take", mk(1, w_of(5, 0, 0, 1, 0), 0, 1, 0));
    out_ready = 1'b0; opcode = 4'h0; rfield = 2'd3;
    for (int k = 0; k < 3; k++) begin
      cflag = ~cflag; zflag = ~zflag;
      #1;
      check($sformatf("stall%0d", k), mk(1, w_of(5, 0, 0, 1, 0), 0, 0, 0));
      tick();
    end
    check("stall_end", mk(1, w_of(5, 0, 0, 1, 0), 0, 0, 0));
    out_ready = 1'b1;
    tick();
    check("after_stall", mk(1, w_of(3, 4'b1000, 0, 0, 0), 0, 1, 0));
    in_valid = 1'b0;
    tick();
    check("stall_drain", mk(0, '0, 0, 1, 0));

    // HALT accepted while previous word is consumed, held for 10 cycles, then resumed.
    in_valid = 1'b1; opcode = 4'h4; rfield = 2'd1;
    tick();
    opcode = 4'hC;
    tick();
    check("halt_enter", mk(0, '0, 1, 0, 0));
    opcode = 4'h4; rfield = 2'd2;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("halt_hold%0d", k), mk(0, '0, 1, 0, 0));
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume", mk(0, '0, 0, 1, 0));
    tick();
    check("post_resume", mk(1, w_of(5, 4'b0100, 0, 0, 0), 0, 1, 0));
    in_valid = 1'b0;

    // Illegal opcode counter saturates at 3 with CNT_W=2.
    do_reset();
    in_valid = 1'b1; opcode = 4'h8;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("illcnt%0d", k), mk(1, w_of(0, 0, 0, 0, 1), 0, 1, 2'(ecnt[k])));
    end

    // Reset mid-stall (also clears the saturated counter) and reset in HALT.
    opcode = 4'h4; rfield = 2'd0;
    tick();
    out_ready = 1'b0; opcode = 4'hF;
    tick();
    rst = 1'b1;
    tick();
    check("rst_stall", mk(0, '0, 0, 1, 0));
    rst = 1'b0; out_ready = 1'b1; opcode = 4'hC;
    tick();
    check("halt_before_rst", mk(0, '0, 1, 0, 3'(0)));
    rst = 1'b1;
    tick();
    check("rst_halt", mk(0, '0, 0, 1, 0));
    rst = 1'b0; in_valid = 1'b0;

    // NREG=3 instance: r=3 is out of range; IN/Im codes move down by one.
    do_reset();
    in_valid3 = 1'b1;
    opcode3 = 4'h0; rfield3 = 2'd3; tick();
    cmp("n3_add_r3", {out_valid3, ds3, load_reg3, load_out3, illegal3, illegal_cnt3},
        {1'b1, 3'd0, 3'b000, 1'b0, 1'b1, 8'd1});
    opcode3 = 4'h0; rfield3 = 2'd2; tick();
    cmp("n3_add_r2", {out_valid3, ds3, load_reg3, load_out3, illegal3, illegal_cnt3},
        {1'b1, 3'd2, 3'b100, 1'b0, 1'b0, 8'd1});
    opcode3 = 4'h3; rfield3 = 2'd1; tick();
    cmp("n3_in_r1", {out_valid3, ds3, load_reg3, load_out3, illegal3, illegal_cnt3},
        {1'b1, 3'd3, 3'b010, 1'b0, 1'b0, 8'd1});
    opcode3 = 4'h4; rfield3 = 2'd0; tick();
    cmp("n3_movim", {out_valid3, ds3, load_reg3, load_out3, illegal3, illegal_cnt3},
        {1'b1, 3'd4, 3'b001, 1'b0, 1'b0, 8'd1});
    opcode3 = 4'h5; rfield3 = 2'd3; tick();
    cmp("n3_out_r3", {out_valid3, ds3, load_reg3, load_out3, illegal3, illegal_cnt3},
        {1'b1, 3'd0, 3'b000, 1'b0, 1'b1, 8'd2});
    in_valid3 = 1'b0;

    // Randomized run against a transaction model.
    do_reset();
    m_valid = 1'b0; m_halt = 1'b0; m_w = '0; m_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      opcode    = 4'($urandom_range(0, 15));
      rfield    = 2'($urandom_range(0, 3));
      cflag     = 1'($urandom_range(0, 1));
      zflag     = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      resume    = ($urandom_range(0, 3) == 0);
      #1;
      ir = !m_halt && (!m_valid || out_ready);
      check($sformatf("rand%0d", n), mk(m_valid, m_w, m_halt, ir, 2'(m_cnt)));
      ref_dec(opcode, rfield, cflag, zflag, w, h);
      if (m_valid && out_ready) m_valid = 1'b0;
      if (ir && in_valid) begin
        if (h) begin
          m_halt = 1'b1;
        end else begin
          m_valid = 1'b1;
          m_w     = w;
          if (w.ill && m_cnt < 3) m_cnt++;
        end
      end else if (m_halt && resume) begin
        m_halt = 1'b0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
